ps2_kbd_matrix: RTL and testbench
=================================

PS2_KBD_MATRIX -- requirements
Module: ps2_kbd_matrix

Interface
REQ-001 CLK  input  1  system clock (14 MHz ULA clock); all state on rising edge.
REQ-002 nRESET  input  1  asynchronous, active-low reset.
REQ-003 PS2_CLK  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-004 PS2_DAT  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-005 addr  input  16  CPU address; addr[15:8] selects matrix half-rows, active-low.
REQ-006 key_data  output  5  active-low column data for the ULA port-FE read.
REQ-007 F1  output  1  high while F1 (set-2 code 0x05) is held.
REQ-008 F11  output  1  high while F11 (set-2 code 0x78) is held.
REQ-009 Parameter TIMEOUT_BITS, default 14, sets the frame-abort timeout to 2^TIMEOUT_BITS CLK cycles.

Function
REQ-010 PS2_CLK and PS2_DAT SHALL each pass through a 2-flop synchronizer; a PS2_CLK falling edge is detected from synchronized samples (previous 1, current 0).
REQ-011 The receiver FSM SHALL have states IDLE, SHIFT and STOP.
- IDLE: on a falling edge with DAT=0 (start bit), go to SHIFT with bit count 0. A start bit of 1 is ignored.
REQ-012 In SHIFT, each falling edge SHALL shift DAT into a 9-bit register, LSB first (8 data bits, then parity); after the 9th bit, go to STOP.
REQ-013 In STOP, the next falling edge SHALL validate the frame and return to IDLE.
- Valid = stop bit 1 and odd parity over data+parity.
- A valid frame raises a 1-cycle byte strobe in the following CLK cycle.
- An invalid frame is discarded and clears the E0/F0 flags.
REQ-014 A timeout counter SHALL reset on every falling edge and count while not IDLE; reaching 2^TIMEOUT_BITS-1 returns the FSM to IDLE and discards the partial frame, with flags unchanged.
REQ-015 Decoder: byte 0xE0 sets ext; 0xF0 sets rel; any other byte is applied as make (rel=0) or break (rel=1), then both flags clear in the same cycle.
REQ-016 Applying a code SHALL write one bit of a 40-bit key state (8 rows x 5 cols); 1 = pressed.
- The set-2 table lives in the package. Non-ext codes map per table.
- With ext=1, only 0x5A (Enter) maps; all other ext codes, including fake shift E0 12, are ignored.
REQ-017 Fixed map entries (row,col):
- 0x12 L-Shift -> CAPS SHIFT (0,0); 0x59 R-Shift -> SYMBOL SHIFT (7,1).
- 0x1C A -> (1,0); 0x15 Q -> (2,0); 0x16 '1' -> (3,0); 0x45 '0' -> (4,0); 0x4D P -> (5,0); 0x5A Enter -> (6,0); 0x29 Space -> (7,0).
REQ-018 0x66 Backspace SHALL set/clear both CAPS SHIFT and '0'.
- The CAPS SHIFT output bit is the OR of the L-Shift and Backspace sources, so releasing one while the other is held leaves CS pressed.
REQ-019 Codes 0x05 and 0x78 SHALL drive F1 and F11 registers, make=1 / break=0; unmapped codes change no state.
REQ-020 key_data[c] SHALL be combinational: NOT OR over rows r where addr[8+r]=0 of state[r][c].
- All addr[15:8] high gives 5'h1F; multiple low rows AND together (active-low).
REQ-021 The byte strobe SHALL be registered, so a matrix update is visible on key_data 1 CLK cycle after the strobe (2 cycles after the stop-bit edge is synchronized).

Reset
REQ-022 nRESET low SHALL immediately apply:
- FSM=IDLE; shift register, bit count and timeout = 0.
- Synchronizers = 1; ext = rel = 0.
- Key state all released, so key_data = 5'h1F.
- F1 = F11 = 0.
REQ-023 Reset mid-frame SHALL discard the partial frame; the first falling edge after release is treated as a potential start bit.

Structure
REQ-024 Package ps2_kbd_pkg SHALL hold the receiver state enum, the row/col constants and the scancode-to-(row,col) lookup function.
REQ-025 Sub-module ps2_rx (synchronizer, FSM, timeout, parity) SHALL output byte[7:0] and a valid strobe; the top level holds the decoder and matrix.

Verification
REQ-026 Frame 0x1C (A make), addr=16'hFDFE -> key_data=5'h1E; then F0 1C -> 5'h1F.
REQ-027 Press L-Shift and Space, addr=16'h7EFE -> key_data=5'h1E (CS and Space on bit 0, AND of rows); addr=16'h7FFE -> 5'h1E; addr=16'hFFFE -> 5'h1F.
REQ-028 Frame 0x16 with parity bit flipped -> no change to key_data (5'h1F at addr 16'hF7FE); the next good frame is decoded normally.
REQ-029 Send 4 bits of a frame, idle 2^14 CLK cycles, then full frame 0x15 -> Q pressed (addr 16'hFBFE gives 5'h1E).
REQ-030 E0 5A -> Enter pressed (addr 16'hBFFE gives 5'h1E); E0 12 -> no change; 0x05 -> F1=1; F0 05 -> F1=0.
REQ-031 Assert nRESET mid-frame while A is held -> key_data=5'h1F and F1=F11=0 immediately; after release, frame 0x4D -> P pressed (addr 16'hDFFE gives 5'h1E).

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// PS/2 keyboard to ZX matrix: shared types, matrix geometry and the
// set-2 scancode lookup table.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_STOP  = 2'd2
    } rx_state_e;

    localparam int ROWS = 8;
    localparam int COLS = 5;
    localparam int KEYS = ROWS * COLS;

    localparam int ROW_CS   = 0;
    localparam int COL_CS   = 0;
    localparam int ROW_ZERO = 4;
    localparam int COL_ZERO = 0;
    localparam int CS_IDX   = ROW_CS * COLS + COL_CS;
    localparam int ZERO_IDX = ROW_ZERO * COLS + COL_ZERO;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_REL  = 8'hF0;
    localparam logic [7:0] SC_BKSP = 8'h66;
    localparam logic [7:0] SC_F1   = 8'h05;
    localparam logic [7:0] SC_F11  = 8'h78;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_loc_t;

    function automatic key_loc_t at(input logic [2:0] r, input logic [2:0] c);
        key_loc_t l;
        l.hit = 1'b1;
        l.row = r;
        l.col = c;
        return l;
    endfunction

    function automatic key_loc_t key_lookup(input logic ext, input logic [7:0] code);
        key_loc_t l;
        l = '0;
        if (ext) begin
            if (code == 8'h5A) l = at(3'd6, 3'd0);
        end else begin
            case (code)
                8'h12:   l = at(3'd0, 3'd0);
                8'h59:   l = at(3'd7, 3'd1);
                8'h1C:   l = at(3'd1, 3'd0);
                8'h15:   l = at(3'd2, 3'd0);
                8'h16:   l = at(3'd3, 3'd0);
                8'h45:   l = at(3'd4, 3'd0);
                8'h4D:   l = at(3'd5, 3'd0);
                8'h5A:   l = at(3'd6, 3'd0);
                8'h29:   l = at(3'd7, 3'd0);
                default: l = '0;
            endcase
        end
        return l;
    endfunction

    function automatic logic [5:0] key_index(input key_loc_t l);
        return 6'(l.row) * 6'd5 + 6'(l.col);
    endfunction

endpackage

// File: rtl/ps2_kbd_matrix_if.sv
// CPU-side port: half-row address in, active-low column data out.
interface ps2_kbd_matrix_if;
    logic [15:0] addr;
    logic [4:0]  key_data;

    modport master (output addr, input  key_data);
    modport slave  (input  addr, output key_data);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, start/data/parity/stop FSM,
// and a frame-abort timeout.
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_BITS = 14
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam logic [1:0] S_IDLE  = RX_IDLE;
    localparam logic [1:0] S_SHIFT = RX_SHIFT;
    localparam logic [1:0] S_STOP  = RX_STOP;

    logic [1:0]              clk_sync;
    logic [1:0]              dat_sync;
    logic                    clk_prev;
    logic [1:0]              state;
    logic [8:0]              sr;
    logic [3:0]              bit_cnt;
    logic [TIMEOUT_BITS-1:0] tmo;
    logic                    fall;
    logic                    dat;

    assign fall = clk_prev & ~clk_sync[1];
    assign dat  = dat_sync[1];

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
            state    <= S_IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            tmo      <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            clk_prev <= clk_sync[1];
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;

            if (state == S_IDLE || fall) tmo <= '0;
            else                         tmo <= tmo + 1'b1;

            // A stalled frame is dropped silently; decoder flags survive
            if (state != S_IDLE && &tmo) begin
                state   <= S_IDLE;
                sr      <= '0;
                bit_cnt <= '0;
            end else if (fall) begin
                unique case (1'b1)
                    (state == S_IDLE): begin
                        if (!dat) begin
                            state   <= S_SHIFT;
                            sr      <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    (state == S_SHIFT): begin
                        sr      <= {dat, sr[8:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd8) state <= S_STOP;
                    end
                    (state == S_STOP): begin
                        if (dat && ^sr) begin
                            rx_byte  <= sr[7:0];
                            rx_valid <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_matrix.sv
// PS/2 set-2 keyboard mapped onto the 8x5 ZX key matrix, read
// through the ULA port-FE half-row address lines.
module ps2_kbd_matrix
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_BITS = 14
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             PS2_CLK,
    input  logic             PS2_DAT,
    ps2_kbd_matrix_if.slave  bus,
    output logic             F1,
    output logic             F11
);

    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            rx_err;
    logic [KEYS-1:0] keys;
    logic [KEYS-1:0] cells;
    logic            bksp;
    logic            ext;
    logic            rel;
    logic [COLS-1:0] act;
    key_loc_t        loc;
    logic [5:0]      idx;

    ps2_rx #(.TIMEOUT_BITS(TIMEOUT_BITS)) u_rx (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    assign loc = key_lookup(ext, rx_byte);
    assign idx = key_index(loc);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            keys <= '0;
            bksp <= 1'b0;
            ext  <= 1'b0;
            rel  <= 1'b0;
            F1   <= 1'b0;
            F11  <= 1'b0;
        end else if (rx_err) begin
            ext <= 1'b0;
            rel <= 1'b0;
        end else if (rx_valid) begin
            unique case (1'b1)
                (rx_byte == SC_EXT): ext <= 1'b1;
                (rx_byte == SC_REL): rel <= 1'b1;
                default: begin
                    if (loc.hit) keys[idx] <= ~rel;
                    if (!ext) begin
                        if (rx_byte == SC_BKSP) begin
                            bksp           <= ~rel;
                            keys[ZERO_IDX] <= ~rel;
                        end
                        if (rx_byte == SC_F1)  F1  <= ~rel;
                        if (rx_byte == SC_F11) F11 <= ~rel;
                    end
                    ext <= 1'b0;
                    rel <= 1'b0;
                end
            endcase
        end
    end

    // Backspace is a second CAPS SHIFT source, merged only on read-out
    always_comb begin
        cells         = keys;
        cells[CS_IDX] = keys[CS_IDX] | bksp;
        act           = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!bus.addr[8+r] && cells[r*COLS+c]) act[c] = 1'b1;
            end
        end
    end

    assign bus.key_data = ~act;

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Self-checking bench: PS/2 frames in, scancode-level key model,
// per-cycle output compare plus literal spot checks.
module tb_ps2_kbd_matrix;

    localparam int H = 10;

    logic CLK = 1'b0;
    logic nRESET = 1'b0;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;
    logic F1;
    logic F11;

    ps2_kbd_matrix_if bus();

    ps2_kbd_matrix #(.TIMEOUT_BITS(14)) dut (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .bus     (bus.slave),
        .F1      (F1),
        .F11     (F11)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    bit m[8][5];
    bit m_bk, m_f1, m_f11, m_ext, m_rel;
    bit chk_en = 1'b0;

    logic [7:0] pool [14] = '{8'h12, 8'h59, 8'h1C, 8'h15, 8'h16, 8'h45,
                              8'h4D, 8'h5A, 8'h29, 8'h66, 8'h05, 8'h78,
                              8'h33, 8'h1B};

    // Key position as row*8+col, or -1 when the code maps nowhere
    function automatic int pos(input bit ext, input logic [7:0] c);
        if (ext) return (c == 8'h5A) ? 48 : -1;
        case (c)
            8'h12: return 0;
            8'h59: return 57;
            8'h1C: return 8;
            8'h15: return 16;
            8'h16: return 24;
            8'h45: return 32;
            8'h4D: return 40;
            8'h5A: return 48;
            8'h29: return 56;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int p;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else begin
            p = pos(m_ext, b);
            if (p >= 0) m[p/8][p%8] = !m_rel;
            if (!m_ext) begin
                if (b == 8'h66) begin
                    m_bk = !m_rel;
                    m[4][0] = !m_rel;
                end
                if (b == 8'h05) m_f1 = !m_rel;
                if (b == 8'h78) m_f11 = !m_rel;
            end
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++) m[r][c] = 1'b0;
        m_bk = 0; m_f1 = 0; m_f11 = 0; m_ext = 0; m_rel = 0;
    endtask

    function automatic logic [4:0] exp_kd(input logic [15:0] a);
        logic [4:0] k;
        k = 5'h1F;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!a[8+r] && (m[r][c] || (r == 0 && c == 0 && m_bk)))
                    k[c] = 1'b0;
        return k;
    endfunction

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en && nRESET) begin
            check("kd_model", {3'b0, bus.key_data}, {3'b0, exp_kd(bus.addr)});
            check("f1_model", {7'b0, F1}, {7'b0, m_f1});
            check("f11_model", {7'b0, F11}, {7'b0, m_f11});
        end
    end

    task automatic ps2_bit(input bit d);
        PS2_DAT = d;
        repeat (H) @(posedge CLK);
        PS2_CLK = 1'b0;
        repeat (H) @(posedge CLK);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits = 11,
                              input bit bad_par = 0, input bit bad_stop = 0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        chk_en = 1'b0;
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        PS2_DAT = 1'b1;
        repeat (8) @(posedge CLK);
        if (nbits == 11) begin
            if (!bad_par && !bad_stop) model_byte(b);
            else begin
                m_ext = 1'b0;
                m_rel = 1'b0;
            end
        end
        chk_en = 1'b1;
    endtask

    task automatic kd(input string name, input logic [15:0] a,
                      input logic [4:0] e);
        @(posedge CLK);
        bus.addr = a;
        @(negedge CLK);
        check(name, {3'b0, bus.key_data}, {3'b0, e});
    endtask

    task automatic gap();
        repeat (6) begin
            @(posedge CLK);
            bus.addr = 16'($urandom);
        end
    endtask

    initial begin
        int op;
        logic [7:0] code;
        model_reset();
        bus.addr = 16'hFFFF;
        repeat (3) @(posedge CLK);
        kd("reset_kd", 16'h0000, 5'h1F);
        check("reset_f1", {7'b0, F1}, 8'h00);
        check("reset_f11", {7'b0, F11}, 8'h00);
        @(posedge CLK);
        nRESET = 1'b1;
        repeat (4) @(posedge CLK);
        chk_en = 1'b1;

        send_frame(8'h1C);
        kd("a_make", 16'hFDFE, 5'h1E);
        send_frame(8'hF0);
        send_frame(8'h1C);
        kd("a_break", 16'hFDFE, 5'h1F);

        send_frame(8'hF0);
        send_frame(8'h1C, 11, 0, 1);
        send_frame(8'h1C);
        kd("err_clears_rel", 16'hFDFE, 5'h1E);
        send_frame(8'hF0);
        send_frame(8'h1C);

        send_frame(8'h12);
        send_frame(8'h29);
        kd("cs_space_7E", 16'h7EFE, 5'h1E);
        kd("cs_space_7F", 16'h7FFE, 5'h1E);
        kd("cs_space_FF", 16'hFFFE, 5'h1F);
        send_frame(8'hF0); send_frame(8'h29);

        send_frame(8'h66);
        send_frame(8'hF0); send_frame(8'h12);
        kd("bksp_cs_held", 16'hFEFE, 5'h1E);
        kd("bksp_zero", 16'hEFFE, 5'h1E);
        send_frame(8'hF0); send_frame(8'h66);
        kd("bksp_cs_rel", 16'hFEFE, 5'h1F);

        send_frame(8'h16, 11, 1, 0);
        kd("bad_parity", 16'hF7FE, 5'h1F);
        send_frame(8'h16);
        kd("after_bad", 16'hF7FE, 5'h1E);
        send_frame(8'hF0); send_frame(8'h16);

        send_frame(8'h15, 4);
        repeat (16400) @(posedge CLK);
        send_frame(8'h15);
        kd("timeout_q", 16'hFBFE, 5'h1E);
        send_frame(8'hF0); send_frame(8'h15);

        send_frame(8'hE0);
        send_frame(8'h33, 4);
        repeat (16400) @(posedge CLK);
        send_frame(8'h5A);
        kd("ext_enter", 16'hBFFE, 5'h1E);
        send_frame(8'hE0); send_frame(8'h12);
        kd("fake_shift", 16'hFEFE, 5'h1F);
        send_frame(8'h05);
        check("f1_make", {7'b0, F1}, 8'h01);
        send_frame(8'hF0); send_frame(8'h05);
        check("f1_break", {7'b0, F1}, 8'h00);
        send_frame(8'h78);
        check("f11_make", {7'b0, F11}, 8'h01);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h5A);
        kd("enter_rel", 16'hBFFE, 5'h1F);

        for (int n = 0; n < 45; n++) begin
            op = $urandom_range(0, 9);
            code = pool[$urandom_range(0, 13)];
            if (op <= 4) send_frame(code);
            else if (op <= 7) begin
                send_frame(8'hF0); send_frame(code);
            end else if (op == 8) begin
                send_frame(8'hE0);
                if ($urandom_range(0, 1) == 1) send_frame(8'hF0);
                send_frame($urandom_range(0, 1) == 1 ? 8'h5A : code);
            end else begin
                send_frame(code, 11, 1'($urandom_range(0, 1)), 1'b1);
            end
            gap();
        end

        send_frame(8'h1C);
        send_frame(8'h05);
        send_frame(8'h78);
        bus.addr = 16'hFDFE;
        send_frame(8'h4D, 5);
        chk_en = 1'b0;
        @(posedge CLK);
        #2 nRESET = 1'b0;
        #1;
        check("rst_mid_kd", {3'b0, bus.key_data}, 8'h1F);
        check("rst_mid_f1", {7'b0, F1}, 8'h00);
        check("rst_mid_f11", {7'b0, F11}, 8'h00);
        model_reset();
        repeat (3) @(posedge CLK);
        nRESET = 1'b1;
        repeat (4) @(posedge CLK);
        chk_en = 1'b1;
        send_frame(8'h4D);
        kd("p_after_rst", 16'hDFFE, 5'h1E);
        gap();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
